// File: rtl/hyperbus_cfg_regs_shadow.sv
// HyperBus configuration register file with a shadow copy written by software and an
// active copy driven to the controller, swapped atomically once the PHY is idle.
package hyperbus_cfg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
    logic [15:0] t_burst_max;
    logic [3:0]  t_read_write_recovery;
    logic [3:0]  t_rx_clk_delay;
    logic [3:0]  t_tx_clk_delay;
    logic [4:0]  address_mask_msb;
    logic        address_space;
    logic        phys_in_use;
    logic        which_phy;
  } hyper_cfg_t;
endpackage

module hyperbus_cfg_regs_shadow #(
  parameter int unsigned NumChips      = 2,
  parameter int unsigned NumPhys       = 1,
  parameter int unsigned RegAddrWidth  = 32,
  parameter int unsigned RegDataWidth  = 32,
  parameter int unsigned CommitTimeout = 1024,
  parameter type reg_req_t = hyperbus_cfg_pkg::reg_req_t,
  parameter type reg_rsp_t = hyperbus_cfg_pkg::reg_rsp_t,
  parameter type rule_t    = hyperbus_cfg_pkg::rule_t,
  parameter logic [RegAddrWidth-1:0] RstChipBase  = '0,
  parameter logic [RegAddrWidth-1:0] RstChipSpace = 'h400_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  reg_req_t                     reg_req_i,
  output reg_rsp_t                     reg_rsp_o,
  output hyperbus_cfg_pkg::hyper_cfg_t cfg_o,
  output rule_t                        chip_rules_o [NumChips],
  input  logic                         trans_active_i,
  output logic                         cfg_hold_o,
  output logic                         cfg_updated_o,
  output logic                         commit_err_o
);

  localparam int unsigned NumRegs  = 10 + 2 * NumChips;
  localparam int unsigned IdxW     = $clog2(NumRegs + 3);
  localparam int unsigned ByteOffW = $clog2(RegDataWidth / 8);
  localparam int unsigned StrbW    = RegDataWidth / 8;
  localparam int unsigned TimerW   = $clog2(CommitTimeout);
  localparam logic [IdxW-1:0] DataEnd   = IdxW'(NumRegs);
  localparam logic [IdxW-1:0] StatusIdx = IdxW'(NumRegs);
  localparam logic [IdxW-1:0] CommitIdx = IdxW'(NumRegs + 1);
  localparam logic [IdxW-1:0] CtrlIdx   = IdxW'(NumRegs + 2);

  typedef enum logic [1:0] {StIdle, StWait, StApply} state_e;

  function automatic logic [RegDataWidth-1:0] field_mask(input int unsigned i);
    logic [RegDataWidth-1:0] m;
    m = '0;
    case (i)
      0, 3, 4, 5: m[3:0]  = '1;
      1, 7:       m[0]    = 1'b1;
      2:          m[15:0] = '1;
      6:          m[4:0]  = '1;
      8, 9:       m[0]    = (NumPhys > 1);
      default:    m       = '1;
    endcase
    return m;
  endfunction

  function automatic logic [RegDataWidth-1:0] rst_val(input int unsigned i);
    logic [RegAddrWidth-1:0] a;
    a = '0;
    if (i >= 10) begin
      a = RstChipBase + RstChipSpace * RegAddrWidth'((i - 10) / 2);
      if (i % 2 == 1) a = a + RstChipSpace;
    end
    case (i)
      0, 3:    return RegDataWidth'(6);
      1, 7:    return '0;
      2:       return RegDataWidth'(350);
      4, 5:    return RegDataWidth'(8);
      6:       return RegDataWidth'(25);
      8, 9:    return RegDataWidth'(NumPhys - 1);
      default: return RegDataWidth'(a);
    endcase
  endfunction

  logic [RegDataWidth-1:0] shadow_q [NumRegs];
  logic [RegDataWidth-1:0] active_q [NumRegs];
  logic                    auto_commit_q, commit_err_q, cfg_updated_q;
  logic [TimerW-1:0]       timer_q;
  state_e                  state_q, state_d;

  logic [IdxW-1:0]         idx;
  logic [RegDataWidth-1:0] bmask, rdata;
  logic is_data, is_bad, req_wr, wr_stall, shadow_we, ctrl_we, commit_we;
  logic commit_req, err_clr, err_set, diff;

  logic unused_addr;
  assign unused_addr = ^{reg_req_i.addr[ByteOffW-1:0], reg_req_i.addr[RegAddrWidth-1:ByteOffW+IdxW]};

  // Request decode: stalls only apply to registers the commit copies or controls.
  always_comb begin
    idx       = reg_req_i.addr[ByteOffW +: IdxW];
    is_data   = idx < DataEnd;
    is_bad    = idx > CtrlIdx;
    req_wr    = reg_req_i.valid && reg_req_i.write;
    wr_stall  = req_wr && (is_data || idx == CtrlIdx) && (state_q != StIdle);
    shadow_we = req_wr && is_data && (state_q == StIdle);
    ctrl_we   = req_wr && (idx == CtrlIdx) && (state_q == StIdle);
    commit_we = req_wr && (idx == CommitIdx);
    commit_req = (commit_we && reg_req_i.wdata[0]) || (shadow_we && auto_commit_q);
    err_clr   = commit_we && reg_req_i.wdata[1];
    bmask = '0;
    for (int b = 0; b < StrbW; b++) bmask[8*b +: 8] = {8{reg_req_i.wstrb[b]}};
  end

  always_comb begin
    rdata = '0;
    diff  = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      diff = diff | (shadow_q[i] != active_q[i]);
      if (idx == IdxW'(i)) rdata = shadow_q[i];
    end
    if (idx == StatusIdx) rdata[2:0] = {commit_err_q, diff, state_q != StIdle};
    if (idx == CtrlIdx)   rdata[0]   = auto_commit_q;
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.rdata = rdata;
    reg_rsp_o.error = reg_req_i.valid && is_bad;
    reg_rsp_o.ready = !wr_stall;
  end

  // Commit sequencing: hold the controller, wait for idle, then copy in one cycle.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      StIdle: if (commit_req) state_d = StWait;
      StWait: begin
        if (!trans_active_i && timer_q != '0) begin
          state_d = StApply;
        end else if (timer_q == TimerW'(CommitTimeout - 1)) begin
          state_d = StIdle;
          err_set = 1'b1;
        end
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      auto_commit_q <= 1'b0;
      commit_err_q  <= 1'b0;
      cfg_updated_q <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        shadow_q[i] <= rst_val(i);
        active_q[i] <= rst_val(i);
      end
    end else begin
      state_q       <= state_d;
      timer_q       <= (state_q == StWait) ? timer_q + 1'b1 : '0;
      cfg_updated_q <= (state_q == StApply);
      if (ctrl_we) auto_commit_q <= reg_req_i.wdata[0];
      if (err_set)      commit_err_q <= 1'b1;
      else if (err_clr) commit_err_q <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        if (shadow_we && idx == IdxW'(i))
          shadow_q[i] <= ((shadow_q[i] & ~bmask) | (reg_req_i.wdata & bmask)) & field_mask(i);
        if (state_q == StApply) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign cfg_hold_o    = (state_q != StIdle);
  assign cfg_updated_o = cfg_updated_q;
  assign commit_err_o  = commit_err_q;

  assign cfg_o.t_latency_access      = active_q[0][3:0];
  assign cfg_o.en_latency_additional = active_q[1][0];
  assign cfg_o.t_burst_max           = active_q[2][15:0];
  assign cfg_o.t_read_write_recovery = active_q[3][3:0];
  assign cfg_o.t_rx_clk_delay        = active_q[4][3:0];
  assign cfg_o.t_tx_clk_delay        = active_q[5][3:0];
  assign cfg_o.address_mask_msb      = active_q[6][4:0];
  assign cfg_o.address_space         = active_q[7][0];
  assign cfg_o.phys_in_use           = active_q[8][0];
  assign cfg_o.which_phy             = active_q[9][0];

  logic [NumRegs-1:0] unused_active_bits;
  for (genvar r = 0; r < NumRegs; r++) begin : g_unused
    assign unused_active_bits[r] = ^active_q[r];
  end

  for (genvar c = 0; c < NumChips; c++) begin : g_rules
    assign chip_rules_o[c].idx        = 32'(c);
    assign chip_rules_o[c].start_addr = active_q[10 + 2*c];
    assign chip_rules_o[c].end_addr   = active_q[11 + 2*c];
  end

endmodule

// File: tb/tb_hyperbus_cfg_regs_shadow.sv
// Directed bench: a register-access vector table plus hand-timed commit, stall, timeout,
// auto-commit and reset-abort sequences on two instances (default and short timeout).
module tb_hyperbus_cfg_regs_shadow;
  import hyperbus_cfg_pkg::*;

  logic clk, rst_n, trans_a, trans_b;
  reg_req_t   req_a, req_b;
  reg_rsp_t   rsp_a, rsp_b;
  hyper_cfg_t cfg_a, cfg_b;
  rule_t      rules_a [2];
  rule_t      rules_b [2];
  logic hold_a, hold_b, upd_a, upd_b, err_a, err_b;
  int n_pass, n_total;

  hyperbus_cfg_regs_shadow dut_a (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req_a), .reg_rsp_o(rsp_a), .cfg_o(cfg_a),
    .chip_rules_o(rules_a), .trans_active_i(trans_a), .cfg_hold_o(hold_a),
    .cfg_updated_o(upd_a), .commit_err_o(err_a)
  );

  hyperbus_cfg_regs_shadow #(.CommitTimeout(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req_b), .reg_rsp_o(rsp_b), .cfg_o(cfg_b),
    .chip_rules_o(rules_b), .trans_active_i(trans_b), .cfg_hold_o(hold_b),
    .cfg_updated_o(upd_b), .commit_err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input bit b, input int idx, input bit wr, input logic [31:0] d,
                       input logic [3:0] s);
    reg_req_t r;
    r.addr = 32'(idx) << 2;
    r.write = wr;
    r.wdata = d;
    r.wstrb = s;
    r.valid = 1'b1;
    if (b) req_b = r;
    else req_a = r;
  endtask

  task automatic idle_bus(input bit b);
    if (b) req_b = '0;
    else req_a = '0;
  endtask

  // Drive one write at a negedge; return at the negedge after the accepting posedge.
  task automatic wr1(input bit b, input int idx, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    drive(b, idx, 1'b1, d, s);
    @(negedge clk);
    idle_bus(b);
  endtask

  task automatic rd_chk(input bit b, input int idx, input string name, input logic [31:0] exp);
    drive(b, idx, 1'b0, '0, '0);
    #1;
    chk(name, b ? rsp_b.rdata : rsp_a.rdata, exp);
    idle_bus(b);
  endtask

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_rdy;
  } vec_t;

  vec_t vecs [$];
  int bad, pulses;

  initial begin
    n_pass = 0; n_total = 0;
    vecs.push_back('{0,  0, 32'h0,        4'h0, 32'd6,        0, 1});
    vecs.push_back('{2,  0, 32'h0,        4'h0, 32'd350,      0, 1});
    vecs.push_back('{12, 0, 32'h0,        4'h0, 32'h0400_0000, 0, 1});
    vecs.push_back('{13, 0, 32'h0,        4'h0, 32'h0800_0000, 0, 1});
    vecs.push_back('{10, 0, 32'h0,        4'h0, 32'h0,        0, 1});
    vecs.push_back('{14, 0, 32'h0,        4'h0, 32'h0,        0, 1});
    vecs.push_back('{17, 0, 32'h0,        4'h0, 32'h0,        1, 1});
    vecs.push_back('{14, 1, 32'h7,        4'hF, 32'h0,        0, 1});
    vecs.push_back('{14, 0, 32'h0,        4'h0, 32'h0,        0, 1});
    vecs.push_back('{17, 1, 32'hFFFF_FFFF, 4'hF, 32'h0,       1, 1});
    vecs.push_back('{3,  1, 32'h1234,     4'h1, 32'd6,        0, 1});
    vecs.push_back('{3,  0, 32'h0,        4'h0, 32'd4,        0, 1});
    vecs.push_back('{14, 0, 32'h0,        4'h0, 32'h2,        0, 1});
    vecs.push_back('{3,  1, 32'h6,        4'hF, 32'd4,        0, 1});
    vecs.push_back('{14, 0, 32'h0,        4'h0, 32'h0,        0, 1});
    vecs.push_back('{6,  1, 32'hFFFF_FFFF, 4'hF, 32'd25,      0, 1});
    vecs.push_back('{6,  0, 32'h0,        4'h0, 32'h1F,       0, 1});
    vecs.push_back('{6,  1, 32'd25,       4'hF, 32'h1F,       0, 1});
    vecs.push_back('{15, 0, 32'h0,        4'h0, 32'h0,        0, 1});
    vecs.push_back('{8,  1, 32'h1,        4'hF, 32'h0,        0, 1});
    vecs.push_back('{8,  0, 32'h0,        4'h0, 32'h0,        0, 1});
    vecs.push_back('{16, 0, 32'h0,        4'h0, 32'h0,        0, 1});

    rst_n = 1'b0; trans_a = 1'b0; trans_b = 1'b0;
    req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_t_latency", 32'(cfg_a.t_latency_access), 32'd6);
    chk("rst_t_burst_max", 32'(cfg_a.t_burst_max), 32'd350);
    chk("rst_chip1_start", rules_a[1].start_addr, 32'h0400_0000);
    chk("rst_chip0_end", rules_a[0].end_addr, 32'h0400_0000);
    chk("rst_chip1_idx", rules_a[1].idx, 32'd1);
    chk("rst_hold", 32'(hold_a), 32'd0);
    chk("rst_updated", 32'(upd_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(0, vecs[k].idx, vecs[k].wr, vecs[k].wdata, vecs[k].wstrb);
      #1;
      chk($sformatf("vec%0d_rdata", k), rsp_a.rdata, vecs[k].exp_rdata);
      chk($sformatf("vec%0d_error", k), 32'(rsp_a.error), 32'(vecs[k].exp_err));
      chk($sformatf("vec%0d_ready", k), 32'(rsp_a.ready), 32'(vecs[k].exp_rdy));
    end
    @(negedge clk);
    idle_bus(0);

    // Basic commit: new value appears with the update pulse three cycles after accept.
    wr1(0, 0, 32'd9, 4'hF);
    chk("c1_shadow_only", 32'(cfg_a.t_latency_access), 32'd6);
    wr1(0, 15, 32'h1, 4'hF);
    chk("c1_hold_n0", 32'(hold_a), 32'd1);
    chk("c1_lat_n0", 32'(cfg_a.t_latency_access), 32'd6);
    rd_chk(0, 14, "c1_status_pending", 32'h3);
    @(negedge clk);
    chk("c1_lat_n1", 32'(cfg_a.t_latency_access), 32'd6);
    @(negedge clk);
    chk("c1_lat_n2", 32'(cfg_a.t_latency_access), 32'd6);
    chk("c1_upd_n2", 32'(upd_a), 32'd0);
    @(negedge clk);
    chk("c1_lat_n3", 32'(cfg_a.t_latency_access), 32'd9);
    chk("c1_upd_n3", 32'(upd_a), 32'd1);
    @(negedge clk);
    chk("c1_upd_n4", 32'(upd_a), 32'd0);
    chk("c1_hold_n4", 32'(hold_a), 32'd0);

    // Busy controller: hold stays up, shadow writes stall, apply follows idle.
    trans_a = 1'b1;
    wr1(0, 4, 32'd3, 4'hF);
    wr1(0, 15, 32'h1, 4'hF);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hold_a !== 1'b1) bad++;
      if (i == 10) begin
        drive(0, 4, 1'b1, 32'd5, 4'hF);
        #1;
        chk("busy_write_ready", 32'(rsp_a.ready), 32'd0);
        idle_bus(0);
      end
    end
    chk("busy_hold_cycles_low", 32'(bad), 32'd0);
    rd_chk(0, 4, "busy_shadow_kept", 32'd3);
    chk("busy_rx_active", 32'(cfg_a.t_rx_clk_delay), 32'd8);
    trans_a = 1'b0;
    @(negedge clk);
    chk("busy_rx_apply_cycle", 32'(cfg_a.t_rx_clk_delay), 32'd8);
    chk("busy_hold_apply", 32'(hold_a), 32'd1);
    @(negedge clk);
    chk("busy_rx_applied", 32'(cfg_a.t_rx_clk_delay), 32'd3);
    chk("busy_upd", 32'(upd_a), 32'd1);

    // Auto-commit with a single byte lane into the 16-bit burst field.
    wr1(0, 16, 32'h1, 4'hF);
    rd_chk(0, 16, "auto_ctrl_read", 32'h1);
    wr1(0, 2, 32'hFF, 4'b0001);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (upd_a === 1'b1) pulses++;
    end
    chk("auto_pulses", 32'(pulses), 32'd1);
    chk("auto_burst", 32'(cfg_a.t_burst_max), 32'h1FF);
    rd_chk(0, 14, "auto_status", 32'h0);
    wr1(0, 16, 32'h0, 4'hF);

    // Timeout on the short-timeout instance.
    trans_b = 1'b1;
    wr1(1, 0, 32'd3, 4'hF);
    wr1(1, 15, 32'h1, 4'hF);
    repeat (15) @(negedge clk);
    chk("to_err_n15", 32'(err_b), 32'd0);
    chk("to_hold_n15", 32'(hold_b), 32'd1);
    @(negedge clk);
    chk("to_err_n16", 32'(err_b), 32'd1);
    chk("to_hold_n16", 32'(hold_b), 32'd0);
    chk("to_active_kept", 32'(cfg_b.t_latency_access), 32'd6);
    rd_chk(1, 14, "to_status", 32'h6);
    wr1(1, 15, 32'h2, 4'hF);
    chk("to_err_cleared", 32'(err_b), 32'd0);

    // Error again, then clear-and-commit in one write.
    wr1(1, 15, 32'h1, 4'hF);
    repeat (16) @(negedge clk);
    chk("to2_err", 32'(err_b), 32'd1);
    trans_b = 1'b0;
    wr1(1, 15, 32'h3, 4'hF);
    chk("both_err_cleared", 32'(err_b), 32'd0);
    chk("both_hold", 32'(hold_b), 32'd1);
    repeat (3) @(negedge clk);
    chk("both_lat", 32'(cfg_b.t_latency_access), 32'd3);
    chk("both_upd", 32'(upd_b), 32'd1);

    // Reset in the middle of a commit leaves reset values, no partial update.
    trans_b = 1'b1;
    wr1(1, 0, 32'd5, 4'hF);
    wr1(1, 15, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hold", 32'(hold_b), 32'd0);
    chk("rst_mid_lat", 32'(cfg_b.t_latency_access), 32'd6);
    trans_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk(1, 0, "rst_mid_shadow", 32'd6);
    chk("rst_mid_err", 32'(err_b), 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_mid_no_apply", 32'(cfg_b.t_latency_access), 32'd6);
    chk("rst_a_burst", 32'(cfg_a.t_burst_max), 32'd350);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
